// File: rtl/controle_busca.sv
// Fetch/execute sequencer for a tiny 4-bit accumulator machine: BUSCA presents pc, ESPERA latches the memory word, EXECUTA retires it.
// Every output is a flop; the reset is synchronous and active low.
module controle_busca #(
  parameter logic [3:0] ENDERECO_FINAL = 4'd15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [2:0] instrucao,
  input  logic [3:0] valor,
  output logic [3:0] posicaoMemoria,
  output logic [3:0] regA,
  output logic [3:0] regB,
  output logic [3:0] resultado,
  output logic       carry,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ESPERA  = 3'd2,
    EXECUTA = 3'd3,
    PARADO  = 3'd4
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] reg_a_q, reg_a_d;
  logic [3:0] reg_b_q, reg_b_d;
  logic [3:0] resultado_q, resultado_d;
  logic       carry_q, carry_d;
  logic       ocupado_q, ocupado_d;
  logic       pronto_q, pronto_d;
  logic       erro_q, erro_d;
  logic [2:0] ir_q, ir_d;
  logic [3:0] dado_q, dado_d;
  logic [4:0] soma;

  assign soma = {1'b0, reg_a_q} + {1'b0, reg_b_q};

  always_comb begin
    estado_d    = estado_q;
    pc_d        = pc_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    resultado_d = resultado_q;
    carry_d     = carry_q;
    pronto_d    = pronto_q;
    erro_d      = erro_q;
    ir_d        = ir_q;
    dado_d      = dado_q;

    case (estado_q)
      OCIOSO, PARADO: begin
        if (iniciar) begin
          estado_d    = BUSCA;
          pc_d        = 4'd0;
          reg_a_d     = 4'd0;
          reg_b_d     = 4'd0;
          resultado_d = 4'd0;
          carry_d     = 1'b0;
          pronto_d    = 1'b0;
          erro_d      = 1'b0;
        end
      end
      BUSCA: estado_d = ESPERA;
      ESPERA: begin
        ir_d     = instrucao;
        dado_d   = valor;
        estado_d = EXECUTA;
      end
      EXECUTA: begin
        case (ir_q)
          3'b000: reg_a_d = dado_q;
          3'b001: reg_b_d = dado_q;
          3'b010: {carry_d, resultado_d} = soma;
          3'b011: begin
            resultado_d = reg_a_q - reg_b_q;
            carry_d     = (reg_a_q < reg_b_q);
          end
          default: ;
        endcase
        // The last address stops the run instead of wrapping pc back to 0.
        if (!ir_q[2]) begin
          if (pc_q == ENDERECO_FINAL) begin
            pronto_d = 1'b1;
            estado_d = PARADO;
          end else begin
            pc_d     = pc_q + 4'd1;
            estado_d = BUSCA;
          end
        end else if (ir_q == 3'b100) begin
          pronto_d = 1'b1;
          estado_d = PARADO;
        end else begin
          erro_d   = 1'b1;
          estado_d = PARADO;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    ocupado_d = (estado_d == BUSCA) || (estado_d == ESPERA) || (estado_d == EXECUTA);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      pc_q        <= 4'd0;
      reg_a_q     <= 4'd0;
      reg_b_q     <= 4'd0;
      resultado_q <= 4'd0;
      carry_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      erro_q      <= 1'b0;
      ir_q        <= 3'd0;
      dado_q      <= 4'd0;
    end else begin
      estado_q    <= estado_d;
      pc_q        <= pc_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      resultado_q <= resultado_d;
      carry_q     <= carry_d;
      ocupado_q   <= ocupado_d;
      pronto_q    <= pronto_d;
      erro_q      <= erro_d;
      ir_q        <= ir_d;
      dado_q      <= dado_d;
    end
  end

  assign posicaoMemoria = pc_q;
  assign regA           = reg_a_q;
  assign regB           = reg_b_q;
  assign resultado      = resultado_q;
  assign carry          = carry_q;
  assign ocupado        = ocupado_q;
  assign pronto         = pronto_q;
  assign erro           = erro_q;

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: table of short programs with expected final state, plus reset and restart sequences.
module tb_controle_busca;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [2:0] instrucao;
  logic [3:0] valor;
  logic [3:0] posicaoMemoria, regA, regB, resultado;
  logic       carry, ocupado, pronto, erro;

  logic [6:0] prog [16];
  logic [6:0] mem_q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [27:0] p;
    logic [3:0]  a, b, r;
    logic        c, pr, er;
    logic [3:0]  pc;
    int          cyc;
  } vec_t;

  vec_t vecs [7];
  vec_t sb_q [$];

  controle_busca #(.ENDERECO_FINAL(4'd15)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .instrucao(instrucao), .valor(valor),
    .posicaoMemoria(posicaoMemoria), .regA(regA), .regB(regB),
    .resultado(resultado), .carry(carry), .ocupado(ocupado),
    .pronto(pronto), .erro(erro)
  );

  always #5 clock = ~clock;

  // Program memory samples the address on each edge, so data is valid one cycle later.
  always @(posedge clock) mem_q <= prog[posicaoMemoria];
  assign instrucao = mem_q[6:4];
  assign valor     = mem_q[3:0];

  function automatic logic [6:0] op(input logic [2:0] o, input logic [3:0] v);
    return {o, v};
  endfunction

  function automatic vec_t mk(input logic [27:0] p, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] r, input logic c, input logic pr, input logic er,
                              input logic [3:0] pc, input int cyc);
    vec_t v;
    v.p = p; v.a = a; v.b = b; v.r = r; v.c = c; v.pr = pr; v.er = er; v.pc = pc; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load4(input logic [27:0] p);
    for (int i = 0; i < 16; i++)
      prog[i] = (i < 4) ? p[27 - 7*i -: 7] : op(3'b100, 4'd0);
  endtask

  task automatic check_final(input vec_t e, input int cyc);
    chk("regA", regA, e.a);
    chk("regB", regB, e.b);
    chk("resultado", resultado, e.r);
    chk("carry", carry, e.c);
    chk("pronto", pronto, e.pr);
    chk("erro", erro, e.er);
    chk("pc_final", posicaoMemoria, e.pc);
    chk("ocupado_final", ocupado, 0);
    chk("cycles", cyc, e.cyc);
  endtask

  // Starts a run and retires it against the scoreboard; hold leaves iniciar high throughout.
  task automatic run(input vec_t e, input bit hold);
    int  n;
    bit  done;
    vec_t x;
    sb_q.push_back(e);
    @(negedge clock);
    iniciar = 1'b1;
    @(posedge clock); #1;
    if (!hold) iniciar = 1'b0;
    chk("start_addr", posicaoMemoria, 0);
    chk("start_ocupado", ocupado, 1);
    chk("start_pronto", pronto, 0);
    n = 0;
    done = 0;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (pronto || erro) done = 1;
      else if (posicaoMemoria != 4'(n / 3)) chk("addr_seq", posicaoMemoria, n / 3);
    end
    x = sb_q.pop_front();
    if (!done) begin
      bad++; total++;
      $display("FAIL timeout: no pronto/erro after %0d cycles", n);
    end else begin
      check_final(x, n);
    end
  endtask

  initial begin
    vecs[0] = mk({op(0,3), op(1,5), op(2,0), op(4,0)}, 3, 5, 8,  0, 1, 0, 3, 12);
    vecs[1] = mk({op(0,9), op(1,9), op(2,0), op(4,0)}, 9, 9, 2,  1, 1, 0, 3, 12);
    vecs[2] = mk({op(0,2), op(1,7), op(3,0), op(4,0)}, 2, 7, 11, 1, 1, 0, 3, 12);
    vecs[3] = mk({op(0,7), op(1,2), op(3,0), op(4,0)}, 7, 2, 5,  0, 1, 0, 3, 12);
    vecs[4] = mk({op(0,4), op(6,0), op(0,9), op(4,0)}, 4, 0, 0,  0, 0, 1, 1, 6);
    vecs[5] = mk({op(5,1), op(0,9), op(0,9), op(4,0)}, 0, 0, 0,  0, 0, 1, 0, 3);
    vecs[6] = mk({op(0,6), op(1,3), op(4,0), op(2,0)}, 6, 3, 0,  0, 1, 0, 2, 9);

    reset = 1'b0;
    iniciar = 1'b1;
    load4(vecs[0].p);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_addr", posicaoMemoria, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_regs", {regA, regB, resultado, carry, erro}, 0);
    iniciar = 1'b0;
    @(negedge clock) reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("idle_ocupado", ocupado, 0);

    for (int i = 0; i < 7; i++) begin
      load4(vecs[i].p);
      run(vecs[i], 0);
    end

    // PARADO must hold its outputs while iniciar stays low.
    repeat (4) @(posedge clock);
    #1;
    chk("hold_pronto", pronto, 1);
    chk("hold_pc", posicaoMemoria, 2);
    chk("hold_regA", regA, 6);

    // Full 16-word program stops at the last address.
    for (int i = 0; i < 16; i++) prog[i] = op(3'b000, 4'd1);
    run(mk(28'd0, 1, 0, 0, 0, 1, 0, 15, 48), 0);
    repeat (3) @(posedge clock);
    #1;
    chk("nowrap_pc", posicaoMemoria, 15);
    chk("nowrap_ocupado", ocupado, 0);

    // Reset in the ESPERA cycle of address 2.
    load4(vecs[0].p);
    @(negedge clock) iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk("pre_rst_addr", posicaoMemoria, 2);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("midrst_addr", posicaoMemoria, 0);
    chk("midrst_regs", {regA, regB, resultado, carry, ocupado, pronto, erro}, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_idle", ocupado, 0);
    run(vecs[0], 0);

    // iniciar held high: one run, then an immediate restart from PARADO.
    load4(vecs[1].p);
    run(vecs[1], 1);
    @(posedge clock); #1;
    chk("restart_pronto", pronto, 0);
    chk("restart_ocupado", ocupado, 1);
    chk("restart_regA", regA, 0);
    chk("restart_addr", posicaoMemoria, 0);
    iniciar = 1'b0;
    for (int n = 0; n < 30 && !pronto; n++) begin
      @(posedge clock); #1;
    end
    chk("restart_done", pronto, 1);
    chk("restart_res", resultado, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
